reqrsp_limiter: RTL and testbench

Single-clock throttle stage that sits directly upstream of the reqrsp cut on a reqrsp port. It counts transactions in flight and stalls new requests once MaxOutstanding is reached. It also provides a flush/drain handshake: it stops issuing new requests, waits until all responses have returned, then signals quiescence. Payload is passed through combinationally; only the request valid/ready pair is gated.

---
 rtl/reqrsp_limiter.sv | 158 +++++++++++++++
 tb/tb_reqrsp_limiter.sv | 270 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/reqrsp_limiter.sv
// Outstanding-transaction limiter with flush/drain handshake for a reqrsp port.
// Optional statistics outputs are built when REQRSP_LIMITER_STATS_EN is defined.

package reqrsp_limiter_pkg;
   typedef struct packed {
      logic        q_valid;
      logic [31:0] q;
      logic        p_ready;
   } req_t;

   typedef struct packed {
      logic        q_ready;
      logic        p_valid;
      logic [31:0] p;
   } rsp_t;
endpackage

module reqrsp_limiter #(
   parameter int unsigned MaxOutstanding = 4,
   parameter type req_t = reqrsp_limiter_pkg::req_t,
   parameter type rsp_t = reqrsp_limiter_pkg::rsp_t,
   localparam int unsigned CntWidth = $clog2(MaxOutstanding + 1)
) (
   input  logic                clk_i,
   input  logic                rst_ni,
   input  req_t                slv_req_i,
   output rsp_t                slv_rsp_o,
   output req_t                mst_req_o,
   input  rsp_t                mst_rsp_i,
   input  logic                flush_i,
   output logic                flush_done_o,
   output logic [CntWidth-1:0] outstanding_o
`ifdef REQRSP_LIMITER_STATS_EN
   ,
   output logic [31:0]         stall_cycles_o,
   output logic [CntWidth-1:0] max_outstanding_o
`endif
);

   if (MaxOutstanding < 1) begin : g_param_check
      $error("reqrsp_limiter: MaxOutstanding must be >= 1");
   end

   localparam logic [CntWidth-1:0] MaxCnt = CntWidth'(MaxOutstanding);

   typedef enum logic [1:0] {
      RUN   = 2'd0,
      DRAIN = 2'd1,
      DONE  = 2'd2
   } state_e;

   state_e              state_q, state_d;
   logic [CntWidth-1:0] cnt_q;
   logic                pending_q;
   logic                allow;
   logic                inc;
   logic                dec;

   assign inc = mst_req_o.q_valid & mst_rsp_i.q_ready;
   assign dec = mst_rsp_i.p_valid & slv_req_i.p_ready;

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values regardless of the order the blocks are evaluated in.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q <= RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // NOTE: state_d gets a default before the case so no path leaves it unassigned,
   // which would otherwise infer a latch.
   always_comb begin
      state_d = state_q;
      unique case (state_q)
         RUN: begin
            if (flush_i) state_d = DRAIN;
         end
         DRAIN: begin
            if (!flush_i) begin
               state_d = RUN;
            end else if ((cnt_q == '0) && !pending_q && !inc) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (!flush_i) state_d = RUN;
         end
         default: state_d = RUN;
      endcase
   end

   // Only the request valid/ready pair is gated; a request already shown downstream
   // stays allowed until it completes so valid never drops mid-handshake.
   always_comb begin
      allow             = pending_q | ((state_q == RUN) & (cnt_q < MaxCnt));
      flush_done_o      = (state_q == DONE);
      mst_req_o         = slv_req_i;
      mst_req_o.q_valid = slv_req_i.q_valid & allow;
      slv_rsp_o         = mst_rsp_i;
      slv_rsp_o.q_ready = mst_rsp_i.q_ready & allow;
   end

   // A response with nothing in flight is a protocol error; the count holds at zero.
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q     <= '0;
         pending_q <= 1'b0;
      end else begin
         pending_q <= mst_req_o.q_valid & ~mst_rsp_i.q_ready;
         if (inc && !dec) begin
            cnt_q <= cnt_q + CntWidth'(1);
         end else if (dec && !inc && (cnt_q != '0)) begin
            cnt_q <= cnt_q - CntWidth'(1);
         end
      end
   end

   assign outstanding_o = cnt_q;

`ifdef REQRSP_LIMITER_STATS_EN
   logic [31:0]         stall_q;
   logic [CntWidth-1:0] hwm_q;
   logic                enter_done;

   assign enter_done = (state_d == DONE) && (state_q != DONE);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         stall_q <= '0;
         hwm_q   <= '0;
      end else if (enter_done) begin
         stall_q <= '0;
         hwm_q   <= '0;
      end else begin
         if (slv_req_i.q_valid && !allow && (stall_q != '1)) stall_q <= stall_q + 32'd1;
         if (cnt_q > hwm_q) hwm_q <= cnt_q;
      end
   end

   assign stall_cycles_o    = stall_q;
   assign max_outstanding_o = hwm_q;
`endif

   a_cnt_bound: assert property (@(posedge clk_i) disable iff (!rst_ni)
      cnt_q <= MaxCnt)
      else $error("reqrsp_limiter: outstanding count exceeds MaxOutstanding");

   a_dec_at_zero: assert property (@(posedge clk_i) disable iff (!rst_ni)
      !(dec && !inc && (cnt_q == '0)))
      else $error("reqrsp_limiter: response with no transaction in flight");

   a_valid_stable: assert property (@(posedge clk_i) disable iff (!rst_ni)
      (slv_req_i.q_valid && !slv_rsp_o.q_ready) |=> slv_req_i.q_valid)
      else $error("reqrsp_limiter: upstream dropped q_valid before acceptance");

endmodule

// File: tb/tb_reqrsp_limiter.sv
// Self-checking bench for reqrsp_limiter: reset vectors, directed corner cases
// and randomized traffic against a queue-based reference model.

module tb_reqrsp_limiter;
   import reqrsp_limiter_pkg::*;

   localparam int MAX = 4;

   logic       clk;
   logic       rst_n;
   req_t       slv_req;
   rsp_t       slv_rsp;
   req_t       mst_req;
   rsp_t       mst_rsp;
   logic       flush;
   logic       flush_done;
   logic [2:0] outstanding;
`ifdef REQRSP_LIMITER_STATS_EN
   logic [31:0] stall_cycles;
   logic [2:0]  max_out;
`endif

   reqrsp_limiter #(.MaxOutstanding(MAX)) dut (
      .clk_i        (clk),
      .rst_ni       (rst_n),
      .slv_req_i    (slv_req),
      .slv_rsp_o    (slv_rsp),
      .mst_req_o    (mst_req),
      .mst_rsp_i    (mst_rsp),
      .flush_i      (flush),
      .flush_done_o (flush_done),
      .outstanding_o(outstanding)
`ifdef REQRSP_LIMITER_STATS_EN
      ,
      .stall_cycles_o   (stall_cycles),
      .max_outstanding_o(max_out)
`endif
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int tests_run = 0;
   int tests_failed = 0;
   int hs_seen = 0;

   // Reference model: requests in flight as a queue of ids plus flush progress flags.
   int unsigned in_flight[$];
   int unsigned next_id = 0;
   bit waiting_m = 0;
   bit draining_m = 0;
   bit done_m = 0;
   bit hold_qv = 0;

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      tests_run++;
      if (act !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   function automatic bit allow_m();
      return waiting_m || (!draining_m && !done_m && (in_flight.size() < MAX));
   endfunction

   task automatic model_reset();
      in_flight.delete();
      waiting_m  = 0;
      draining_m = 0;
      done_m     = 0;
      hold_qv    = 0;
   endtask

   // One clock cycle: drive at posedge+1, check before the edge, update model after it.
   task automatic cycle(input bit qv_i, input bit qr, input bit pv_i, input bit pr, input bit fl);
      bit qv, pv, al, acc, rsp, was_idle;
      qv = qv_i | hold_qv;
      pv = pv_i && (in_flight.size() > 0);
      al = allow_m();
      slv_req.q_valid = qv;
      slv_req.q       = $urandom;
      slv_req.p_ready = pr;
      mst_rsp.q_ready = qr;
      mst_rsp.p_valid = pv;
      mst_rsp.p       = $urandom;
      flush           = fl;
      #1;
      check("mst_q_valid", mst_req.q_valid, qv & al);
      check("slv_q_ready", slv_rsp.q_ready, qr & al);
      check("outstanding", outstanding, in_flight.size());
      check("flush_done", flush_done, done_m);
      check("q_payload", mst_req.q, slv_req.q);
      check("p_payload", slv_rsp.p, mst_rsp.p);
      check("p_valid_pass", slv_rsp.p_valid, pv);
      check("p_ready_pass", mst_req.p_ready, pr);
      if (mst_req.q_valid && qr) hs_seen++;
      acc = qv & al & qr;
      rsp = pv & pr;
      was_idle = (in_flight.size() == 0) && !waiting_m && !acc;
      @(posedge clk);
      if (acc) begin
         in_flight.push_back(next_id);
         next_id++;
      end
      if (rsp && in_flight.size() > 0) void'(in_flight.pop_front());
      if (done_m) begin
         if (!fl) done_m = 0;
      end else if (draining_m) begin
         if (!fl) draining_m = 0;
         else if (was_idle) begin
            draining_m = 0;
            done_m     = 1;
         end
      end else if (fl) begin
         draining_m = 1;
      end
      waiting_m = qv & al & ~qr;
      hold_qv   = qv & ~acc;
      #1;
   endtask

   // Steers the bench (while running) to a given in-flight count.
   task automatic settle_to(input int n);
      for (int i = 0; i < 20 && in_flight.size() != n; i++) begin
         if (in_flight.size() > n) cycle(0, 1, 1, 1, 0);
         else cycle(1, 1, 0, 1, 0);
      end
      check("settle_count", outstanding, n);
   endtask

   typedef struct {
      bit          qv, qr, pv, pr;
      logic [31:0] q, p;
      bit          e_qv, e_qr;
   } vec_t;

   initial begin
      vec_t vecs[6];
      bit fl_r;
      vecs[0] = '{0, 0, 0, 0, 32'h0000_0000, 32'h0000_0000, 0, 0};
      vecs[1] = '{1, 0, 0, 1, 32'hdead_beef, 32'h1234_5678, 1, 0};
      vecs[2] = '{1, 1, 1, 1, 32'hffff_ffff, 32'h0000_0000, 1, 1};
      vecs[3] = '{0, 1, 1, 0, 32'ha5a5_a5a5, 32'h5a5a_5a5a, 0, 1};
      vecs[4] = '{1, 1, 0, 0, 32'h0000_0001, 32'h8000_0000, 1, 1};
      vecs[5] = '{0, 0, 1, 1, 32'h7fff_ffff, 32'hcafe_f00d, 0, 0};

      rst_n = 1'b0;
      slv_req = '0;
      mst_rsp = '0;
      flush = 1'b0;
      model_reset();
      #2;
      check("rst_outstanding", outstanding, 0);
      check("rst_flush_done", flush_done, 0);

      // Pass-through and gating with allow=1 (reset state).
      for (int i = 0; i < 6; i++) begin
         slv_req.q_valid = vecs[i].qv;
         slv_req.q       = vecs[i].q;
         slv_req.p_ready = vecs[i].pr;
         mst_rsp.q_ready = vecs[i].qr;
         mst_rsp.p_valid = vecs[i].pv;
         mst_rsp.p       = vecs[i].p;
         #1;
         check("vec_q_valid", mst_req.q_valid, vecs[i].e_qv);
         check("vec_q_ready", slv_rsp.q_ready, vecs[i].e_qr);
         check("vec_q", mst_req.q, vecs[i].q);
         check("vec_p", slv_rsp.p, vecs[i].p);
         check("vec_p_valid", slv_rsp.p_valid, vecs[i].pv);
         check("vec_p_ready", mst_req.p_ready, vecs[i].pr);
      end
      slv_req = '0;
      mst_rsp = '0;
      @(negedge clk);
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Fill to the limit with responses withheld, then free one slot.
      hs_seen = 0;
      for (int i = 0; i < 6; i++) cycle(1, 1, 0, 1, 0);
      check("full_handshakes", hs_seen, 4);
      check("full_outstanding", outstanding, 4);
      check("full_q_ready", slv_rsp.q_ready, 0);
      hs_seen = 0;
      cycle(1, 1, 1, 1, 0);
      check("resp_no_reenable", hs_seen, 0);
      check("after_resp_cnt", outstanding, 3);
      cycle(1, 1, 0, 1, 0);
      check("refill_accepted", hs_seen, 1);
      check("refill_cnt", outstanding, 4);

      // Simultaneous request and response handshakes hold the count.
      settle_to(2);
      for (int i = 0; i < 10; i++) begin
         cycle(1, 1, 1, 1, 0);
         check("steady_cnt", outstanding, 2);
      end

      // Flush while a request is stalled downstream.
      settle_to(0);
      cycle(1, 0, 0, 1, 0);
      cycle(1, 0, 0, 1, 1);
      check("pend_valid_flush", mst_req.q_valid, 1);
      cycle(1, 0, 0, 1, 1);
      check("pend_valid_drain", mst_req.q_valid, 1);
      cycle(1, 1, 0, 1, 1);
      check("drain_cnt1", outstanding, 1);
      cycle(0, 1, 1, 1, 1);
      check("drain_cnt0", outstanding, 0);
      hs_seen = 0;
      for (int i = 0; i < 10 && !flush_done; i++) cycle(1, 1, 0, 1, 1);
      check("drain_done", flush_done, 1);
      cycle(1, 1, 0, 1, 1);
      cycle(1, 1, 0, 1, 1);
      check("done_blocks", hs_seen, 0);
      check("done_held", flush_done, 1);
      cycle(1, 1, 0, 1, 0);
      check("done_release", flush_done, 0);
      check("done_release_hs", hs_seen, 0);
      cycle(1, 1, 0, 1, 0);
      check("resume_hs", hs_seen, 1);

      // Flush on an idle bus: done exactly two cycles after flush rises.
      settle_to(0);
      cycle(0, 1, 0, 1, 1);
      check("idle_flush_c1", flush_done, 0);
      cycle(0, 1, 0, 1, 1);
      check("idle_flush_c2", flush_done, 1);
      cycle(0, 1, 0, 1, 0);
      check("idle_flush_off", flush_done, 0);
      hs_seen = 0;
      cycle(1, 1, 0, 1, 0);
      check("idle_resume_hs", hs_seen, 1);

      // Asynchronous reset mid-operation.
      settle_to(3);
      #2;
      rst_n = 1'b0;
      slv_req = '0;
      mst_rsp = '0;
      flush = 1'b0;
      #1;
      check("async_rst_cnt", outstanding, 0);
      check("async_rst_done", flush_done, 0);
`ifdef REQRSP_LIMITER_STATS_EN
      check("async_rst_stall", stall_cycles, 0);
      check("async_rst_max", max_out, 0);
`endif
      model_reset();
      @(posedge clk);
      #2;
      rst_n = 1'b1;
      @(posedge clk);
      #1;

      // Randomized traffic with occasional flush toggling.
      fl_r = 0;
      for (int i = 0; i < 3000; i++) begin
         if ($urandom_range(39) == 0) fl_r = ~fl_r;
         cycle($urandom_range(1), $urandom_range(3) != 0, $urandom_range(2) == 0,
               $urandom_range(3) != 0, fl_r);
      end

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule
